// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with a small byte FIFO, STATUS/CTRL
// registers and a level interrupt, served over the word-addressed req/ready bus.
module uart_rx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] addr,
    inout  wire  [31:0] data,
    input  logic        req,
    inout  wire         ready,
    input  logic        RW,
    input  logic        RxD,
    output logic        rx_int
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]       DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HI
    } rx_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_HOLD
    } bus_state_e;

    logic [1:0]       sync_q;
    logic             rxs;
    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             expire;
    logic             stop_hit;
    logic             push;
    logic             frame_err;

    bus_state_e       bus_state_q;
    logic             ack_q;
    logic             rw_q;
    logic [1:0]       off_q;
    logic [2:0]       wdata_q;
    logic             hit;
    logic             pop;
    logic             wr_status;
    logic             wr_ctrl;
    logic [31:0]      rdata;
    logic             unused_data;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             push_ok;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             ie_q, ie_d;
    logic             rx_int_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], RxD};
        end
    end

    assign rxs = sync_q[1];

    assign expire    = (cnt_q == '0);
    assign stop_hit  = (rx_state_q == RX_STOP) && expire;
    assign push      = stop_hit & rxs;
    assign frame_err = stop_hit & ~rxs;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rxs) begin
                        cnt_q      <= HALF_C;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (!expire) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (rxs) begin
                        rx_state_q <= RX_IDLE;
                    end else begin
                        cnt_q      <= FULL_C;
                        bit_idx_q  <= '0;
                        rx_state_q <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (!expire) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        shift_q   <= {rxs, shift_q[7:1]};
                        cnt_q     <= FULL_C;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (!expire) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rx_state_q <= RX_WAIT_HI;
                    end
                end
                RX_WAIT_HI: begin
                    // A line held low after the stop sample must not start a new frame.
                    if (rxs) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign hit = req && (addr >= BASE_ADDR) && (addr <= BASE_ADDR + 32'd2);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus_state_q <= S_IDLE;
            ack_q       <= 1'b0;
            rw_q        <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
        end else begin
            case (bus_state_q)
                S_IDLE: begin
                    if (hit) begin
                        off_q       <= 2'(addr - BASE_ADDR);
                        rw_q        <= RW;
                        wdata_q     <= {data[6], data[5], data[0]};
                        ack_q       <= 1'b1;
                        bus_state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q       <= 1'b0;
                    bus_state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (!req) begin
                        bus_state_q <= S_IDLE;
                    end
                end
                default: begin
                    ack_q       <= 1'b0;
                    bus_state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign unused_data = ^{data[31:7], data[4:1]};

    assign pop       = ack_q & rw_q & (off_q == 2'd0) & (count_q != '0);
    assign wr_status = ack_q & ~rw_q & (off_q == 2'd1);
    assign wr_ctrl   = ack_q & ~rw_q & (off_q == 2'd2);

    always_comb begin
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push_ok  = push & ((count_q != DEPTH_C) | pop);
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 5'd1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 5'd1;
        end
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        ovr_d    = (push & ~push_ok) | (ovr_q & ~(wr_status & wdata_q[2]));
        ferr_d   = frame_err | (ferr_q & ~(wr_status & wdata_q[1]));
        ie_d     = wr_ctrl ? wdata_q[0] : ie_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ie_q     <= 1'b0;
            rx_int_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            ie_q     <= ie_d;
            rx_int_q <= ie_q & (count_q != '0);
        end
    end

    always_comb begin
        rdata = '0;
        case (off_q)
            2'd0:    rdata = (count_q != '0) ? {1'b1, 23'b0, mem_q[rd_ptr_q]} : '0;
            2'd1:    rdata = {25'b0, ovr_q, ferr_q, count_q};
            2'd2:    rdata = {31'b0, ie_q};
            default: rdata = '0;
        endcase
    end

    assign data   = (ack_q && rw_q) ? rdata : 'z;
    assign ready  = ack_q ? 1'b1 : 1'bz;
    assign rx_int = rx_int_q;

endmodule
